// File: rtl/serial_tx_if.sv
// Handshake and serial-line bundle for serial_tx.
// The upstream producer uses the master view; the transmitter uses the slave view.
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              tx;
    logic              busy;
    logic              tx_done;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  tx,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output tx,
        output busy,
        output tx_done
    );
endinterface

// File: rtl/serial_tx.sv
// Serial transmitter: accepts one word through a valid/ready handshake and
// sends it as start bit, DATA_W data bits (LSB first), an optional even-parity
// bit and a stop bit, each held for DIV clock cycles. All outputs are registered.
module serial_tx #(
    parameter int DATA_W    = 8,
    parameter int DIV       = 4,
    parameter int PARITY_EN = 1
) (
    input logic         clk,
    input logic         reset,
    serial_tx_if.slave  bus
);

    localparam int CNT_W = $clog2(DIV) + 1;
    localparam int IDX_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_next;
    logic              parity;
    logic              tx_q;
    logic              ready_q;
    logic              done_q;

    assign bus.tx       = tx_q;
    assign bus.in_ready = ready_q;
    assign bus.busy     = ~ready_q;
    assign bus.tx_done  = done_q;

    // Next value of the shift register once the current data bit has been sent.
    always_comb begin
        shift_next = shift >> 1;
    end

    // Frame sequencer: state, bit-period counter, bit index, shift register and line driver.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            parity  <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (ready_q && bus.in_valid) begin
                        shift   <= bus.in_data;
                        parity  <= ^bus.in_data;
                        cnt     <= CNT_RELOAD;
                        bit_idx <= '0;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        state   <= START;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        cnt     <= CNT_RELOAD;
                        bit_idx <= '0;
                        tx_q    <= shift[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        cnt <= CNT_RELOAD;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                tx_q  <= parity;
                                state <= PARITY;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shift   <= shift_next;
                            tx_q    <= shift_next[0];
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (cnt == '0) begin
                        cnt   <= CNT_RELOAD;
                        tx_q  <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        cnt     <= '0;
                        tx_q    <= 1'b1;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed testbench for serial_tx: one instance with DIV=4 and parity,
// one with DIV=1 and no parity, sharing clock and reset.
module tb_serial_tx;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    serial_tx_if #(.DATA_W(8)) bus_a ();
    serial_tx_if #(.DATA_W(8)) bus_b ();

    serial_tx #(.DATA_W(8), .DIV(4), .PARITY_EN(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    serial_tx #(.DATA_W(8), .DIV(1), .PARITY_EN(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expects a DIV=4 frame whose acceptance edge has just passed. bits[0] is the
    // start bit, bits[8:1] the data LSB first, bits[9] parity, bits[10] stop.
    // On the first frame cycle the upstream side is redriven with nv/nd.
    task automatic expect_frame_a(input logic [10:0] bits, input logic nv, input logic [7:0] nd);
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) begin
                    bus_a.in_valid = nv;
                    bus_a.in_data  = nd;
                end
                check("a_frame_tx", 16'(bus_a.tx), 16'(bits[b]));
                check("a_frame_busy", 16'(bus_a.busy), 16'd1);
                check("a_frame_ready", 16'(bus_a.in_ready), 16'd0);
                check("a_frame_done", 16'(bus_a.tx_done), 16'd0);
            end
        end
        @(negedge clk);
        check("a_end_done", 16'(bus_a.tx_done), 16'd1);
        check("a_end_ready", 16'(bus_a.in_ready), 16'd1);
        check("a_end_busy", 16'(bus_a.busy), 16'd0);
        check("a_end_tx", 16'(bus_a.tx), 16'd1);
    endtask

    initial begin
        logic [9:0] bits_b;
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = 8'h00;
        bus_b.in_valid = 1'b0;
        bus_b.in_data  = 8'h00;

        #2;
        check("rst_a_tx", 16'(bus_a.tx), 16'd1);
        check("rst_a_ready", 16'(bus_a.in_ready), 16'd0);
        check("rst_a_busy", 16'(bus_a.busy), 16'd1);
        check("rst_a_done", 16'(bus_a.tx_done), 16'd0);
        check("rst_b_tx", 16'(bus_b.tx), 16'd1);
        check("rst_b_busy", 16'(bus_b.busy), 16'd1);

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle line with no upstream words for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_tx", 16'(bus_a.tx), 16'd1);
            check("idle_busy", 16'(bus_a.busy), 16'd0);
            check("idle_done", 16'(bus_a.tx_done), 16'd0);
        end
        check("idle_ready", 16'(bus_a.in_ready), 16'd1);

        // 0xA5: parity 0.
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'hA5;
        expect_frame_a({1'b1, 1'b0, 8'hA5, 1'b0}, 1'b0, 8'hFF);
        @(negedge clk);
        check("a5_done_single", 16'(bus_a.tx_done), 16'd0);

        // 0x07: three ones, parity 1.
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h07;
        expect_frame_a({1'b1, 1'b1, 8'h07, 1'b0}, 1'b0, 8'h00);
        @(negedge clk);
        check("07_done_single", 16'(bus_a.tx_done), 16'd0);

        // Back-to-back: 0x55 then 0xAA with valid held, data changed mid-frame.
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h55;
        expect_frame_a({1'b1, 1'b0, 8'h55, 1'b0}, 1'b1, 8'hAA);
        expect_frame_a({1'b1, 1'b0, 8'hAA, 1'b0}, 1'b0, 8'h12);
        @(negedge clk);
        check("aa_done_single", 16'(bus_a.tx_done), 16'd0);
        check("aa_idle_ready", 16'(bus_a.in_ready), 16'd1);

        // 0x00 frame aborted by reset during its 20th cycle.
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h00;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("abort_pre_tx", 16'(bus_a.tx), 16'd0);
        check("abort_pre_busy", 16'(bus_a.busy), 16'd1);
        reset = 1'b1;
        #1;
        check("abort_tx", 16'(bus_a.tx), 16'd1);
        check("abort_ready", 16'(bus_a.in_ready), 16'd0);
        check("abort_busy", 16'(bus_a.busy), 16'd1);
        check("abort_done", 16'(bus_a.tx_done), 16'd0);
        #2;
        reset          = 1'b0;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h3C;
        @(negedge clk);
        check("rel_ready", 16'(bus_a.in_ready), 16'd1);
        check("rel_busy", 16'(bus_a.busy), 16'd0);
        check("rel_tx", 16'(bus_a.tx), 16'd1);
        check("rel_done", 16'(bus_a.tx_done), 16'd0);

        // 0x3C after the aborted frame: four ones, parity 0.
        expect_frame_a({1'b1, 1'b0, 8'h3C, 1'b0}, 1'b0, 8'h00);
        @(negedge clk);
        check("3c_done_single", 16'(bus_a.tx_done), 16'd0);

        // DIV=1, no parity, 0xFF: start 0, eight 1s, stop 1 -> 10 cycles.
        bits_b = {1'b1, 8'hFF, 1'b0};
        check("b_idle_ready", 16'(bus_b.in_ready), 16'd1);
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus_b.in_valid = 1'b0;
                bus_b.in_data  = 8'h00;
            end
            check("b_frame_tx", 16'(bus_b.tx), 16'(bits_b[i]));
            check("b_frame_busy", 16'(bus_b.busy), 16'd1);
            check("b_frame_done", 16'(bus_b.tx_done), 16'd0);
        end
        @(negedge clk);
        check("b_end_done", 16'(bus_b.tx_done), 16'd1);
        check("b_end_ready", 16'(bus_b.in_ready), 16'd1);
        check("b_end_tx", 16'(bus_b.tx), 16'd1);
        @(negedge clk);
        check("b_done_single", 16'(bus_b.tx_done), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
